// File: rtl/rv_iommu_ds_rsp.sv
// rtl/rv_iommu_ds_rsp.sv - DS IF AXI4 memory responder with independent read/write FSMs
// Optional: define RV_IOMMU_DS_RSP_DECERR_EN to answer out-of-range beats with DECERR instead of wrapping.

package rv_iommu_ds_rsp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        user;
    } ds_ax_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic        user;
    } ds_w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic       user;
    } ds_b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        user;
    } ds_r_chan_t;

    typedef struct packed {
        ds_ax_chan_t aw;
        logic        aw_valid;
        ds_w_chan_t  w;
        logic        w_valid;
        logic        b_ready;
        ds_ax_chan_t ar;
        logic        ar_valid;
        logic        r_ready;
    } ds_req_t;

    typedef struct packed {
        logic       aw_ready;
        logic       ar_ready;
        logic       w_ready;
        ds_b_chan_t b;
        logic       b_valid;
        ds_r_chan_t r;
        logic       r_valid;
    } ds_rsp_t;

endpackage

module rv_iommu_ds_rsp
    import rv_iommu_ds_rsp_pkg::*;
#(
    parameter type         axi_req_t = logic,
    parameter type         axi_rsp_t = logic,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  axi_req_t   ds_req_i,
    output axi_rsp_t   ds_resp_o,
    input  logic [3:0] rd_lat_i
);

    // Word index width, and a sum width wide enough that base+beat never overflows
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned SW = AW + 9;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    // The caller's struct types are expected to share the package layout
    ds_req_t req;
    ds_rsp_t rsp;
    assign req       = ds_req_t'(ds_req_i);
    assign ds_resp_o = axi_rsp_t'(rsp);

    logic [63:0] mem [MEM_WORDS];

    logic          live;
    r_state_e      r_state;
    logic [3:0]    r_id;
    logic [AW-1:0] r_base;
    logic [7:0]    r_len;
    logic [7:0]    r_beat;
    logic [3:0]    r_lat;
    w_state_e      w_state;
    logic [3:0]    w_id;
    logic [AW-1:0] w_base;
    logic [7:0]    w_beat;
    logic          w_err;

    logic [SW-1:0] r_sum;
    logic [SW-1:0] w_sum;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx;
    logic          r_oor;
    logic          w_oor;
    logic          ar_fire;
    logic          aw_fire;
    logic          r_fire;
    logic          w_fire;
    logic          b_fire;

    assign r_sum = SW'(r_base) + SW'(r_beat);
    assign w_sum = SW'(w_base) + SW'(w_beat);
    assign r_idx = r_sum[AW-1:0];
    assign w_idx = w_sum[AW-1:0];

`ifdef RV_IOMMU_DS_RSP_DECERR_EN
    assign r_oor = (r_sum >= SW'(MEM_WORDS));
    assign w_oor = (w_sum >= SW'(MEM_WORDS));
`else
    assign r_oor = 1'b0;
    assign w_oor = 1'b0;
`endif

    assign ar_fire = rsp.ar_ready & req.ar_valid;
    assign aw_fire = rsp.aw_ready & req.aw_valid;
    assign r_fire  = rsp.r_valid  & req.r_ready;
    assign w_fire  = rsp.w_ready  & req.w_valid;
    assign b_fire  = rsp.b_valid  & req.b_ready;

    // Response channels decoded from FSM state; every field not set here stays zero
    always_comb begin
        rsp          = '0;
        rsp.ar_ready = live && (r_state == R_IDLE);
        rsp.aw_ready = live && (w_state == W_IDLE);
        rsp.w_ready  = (w_state == W_DATA);
        rsp.r_valid  = (r_state == R_DATA);
        rsp.r.id     = r_id;
        rsp.r.data   = r_oor ? 64'd0 : mem[r_idx];
        rsp.r.resp   = r_oor ? RESP_DECERR : RESP_OKAY;
        rsp.r.last   = (r_beat == r_len);
        rsp.b_valid  = (w_state == W_RESP);
        rsp.b.id     = w_id;
        rsp.b.resp   = w_err ? RESP_DECERR : RESP_OKAY;
    end

    // Readies stay low during reset and come up on the first edge after release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // Read FSM: capture AR, wait rd_lat_i cycles, then stream beats until last
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_base  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_lat   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        r_id    <= req.ar.id;
                        r_base  <= req.ar.addr[AW+2:3];
                        r_len   <= req.ar.len;
                        r_beat  <= '0;
                        r_lat   <= rd_lat_i;
                        r_state <= (rd_lat_i == 4'd0) ? R_DATA : R_WAIT;
                    end
                end
                R_WAIT: begin
                    r_lat <= r_lat - 4'd1;
                    if (r_lat <= 4'd1) begin
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (r_beat == r_len) begin
                            r_state <= R_IDLE;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM: capture AW, accept beats until w.last, then hold B until taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_base  <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        w_id    <= req.aw.id;
                        w_base  <= req.aw.addr[AW+2:3];
                        w_beat  <= '0;
                        w_err   <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_beat <= w_beat + 8'd1;
                        w_err  <= w_err | w_oor;
                        if (req.w.last) begin
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_fire) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Byte-masked memory write; contents survive reset
    always_ff @(posedge clk_i) begin
        if (w_fire && !w_oor) begin
            for (int b = 0; b < 8; b++) begin
                if (req.w.strb[b]) begin
                    mem[w_idx][8*b +: 8] <= req.w.data[8*b +: 8];
                end
            end
        end
    end

    // Request fields this responder deliberately ignores
    logic unused_fields;
    assign unused_fields = ^{req.aw.len, req.aw.size, req.aw.burst, req.aw.user,
                             req.aw.addr[63:AW+3], req.aw.addr[2:0],
                             req.ar.size, req.ar.burst, req.ar.user,
                             req.ar.addr[63:AW+3], req.ar.addr[2:0],
                             req.w.user, r_sum[SW-1:AW], w_sum[SW-1:AW]};

endmodule

// File: tb/tb_rv_iommu_ds_rsp.sv
// tb/tb_rv_iommu_ds_rsp.sv - directed self-checking bench for rv_iommu_ds_rsp

module tb_rv_iommu_ds_rsp;
    import rv_iommu_ds_rsp_pkg::*;

    localparam int unsigned MEM_WORDS = 1024;
    localparam logic [63:0] BASE_HI  = 64'((MEM_WORDS - 2) * 8);
    localparam logic [63:0] DAT_A    = 64'hA5A5_0001_DEAD_BEEF;
    localparam logic [63:0] DAT_B    = 64'h5A5A_0002_CAFE_F00D;
    localparam logic [63:0] DAT_D0   = 64'h0000_0000_0000_D0D0;
    localparam logic [63:0] DAT_D1   = 64'h1111_0000_0000_D1D1;
    localparam logic [63:0] DAT_D2   = 64'h2222_0000_0000_D2D2;
    localparam logic [63:0] DAT_D3   = 64'h3333_0000_0000_D3D3;
    localparam logic [63:0] DAT_W0   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] DAT_W1   = 64'hFEDC_BA98_7654_3210;

    logic       clk;
    logic       rst_n;
    logic [3:0] rd_lat;
    ds_req_t    req;
    ds_rsp_t    rsp;
    int         n_asserts;
    int         n_fail;

    rv_iommu_ds_rsp #(
        .axi_req_t (ds_req_t),
        .axi_rsp_t (ds_rsp_t),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .ds_req_i  (req),
        .ds_resp_o (rsp),
        .rd_lat_i  (rd_lat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [63:0] addr);
        req.aw      = '0;
        req.aw.id   = id;
        req.aw.addr = addr;
        req.aw_valid = 1'b1;
        for (int i = 0; i < 20 && !rsp.aw_ready; i++) tick();
        n_asserts++; if (rsp.aw_ready !== 1'b1) begin n_fail++; $error("FAIL aw_ready: observed %0h", rsp.aw_ready); end
        tick();
        req.aw_valid = 1'b0;
    endtask

    task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        req.w.data  = data;
        req.w.strb  = strb;
        req.w.last  = last;
        req.w_valid = 1'b1;
        for (int i = 0; i < 20 && !rsp.w_ready; i++) tick();
        n_asserts++; if (rsp.w_ready !== 1'b1) begin n_fail++; $error("FAIL w_ready: observed %0h", rsp.w_ready); end
        tick();
        req.w_valid = 1'b0;
    endtask

    task automatic do_b(input logic [3:0] id, input logic [1:0] resp);
        req.b_ready = 1'b1;
        for (int i = 0; i < 20 && !rsp.b_valid; i++) tick();
        n_asserts++; if (rsp.b_valid !== 1'b1) begin n_fail++; $error("FAIL b_valid: observed %0h", rsp.b_valid); end
        n_asserts++; if (rsp.b.id !== id) begin n_fail++; $error("FAIL b_id: observed %0h expected %0h", rsp.b.id, id); end
        n_asserts++; if (rsp.b.resp !== resp) begin n_fail++; $error("FAIL b_resp: observed %0h expected %0h", rsp.b.resp, resp); end
        n_asserts++; if (rsp.aw_ready !== 1'b0) begin n_fail++; $error("FAIL aw_ready_during_b: observed %0h", rsp.aw_ready); end
        tick();
        req.b_ready = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len);
        req.ar      = '0;
        req.ar.id   = id;
        req.ar.addr = addr;
        req.ar.len  = len;
        req.ar_valid = 1'b1;
        for (int i = 0; i < 20 && !rsp.ar_ready; i++) tick();
        n_asserts++; if (rsp.ar_ready !== 1'b1) begin n_fail++; $error("FAIL ar_ready: observed %0h", rsp.ar_ready); end
        tick();
        req.ar_valid = 1'b0;
    endtask

    task automatic rd_beat(input logic [63:0] data, input logic [3:0] id,
                           input logic last, input logic [1:0] resp);
        req.r_ready = 1'b1;
        n_asserts++; if (rsp.r_valid !== 1'b1) begin n_fail++; $error("FAIL r_valid: observed %0h", rsp.r_valid); end
        n_asserts++; if (rsp.r.data !== data) begin n_fail++; $error("FAIL r_data: observed %0h expected %0h", rsp.r.data, data); end
        n_asserts++; if (rsp.r.id !== id) begin n_fail++; $error("FAIL r_id: observed %0h expected %0h", rsp.r.id, id); end
        n_asserts++; if (rsp.r.last !== last) begin n_fail++; $error("FAIL r_last: observed %0h expected %0h", rsp.r.last, last); end
        n_asserts++; if (rsp.r.resp !== resp) begin n_fail++; $error("FAIL r_resp: observed %0h expected %0h", rsp.r.resp, resp); end
        n_asserts++; if (rsp.ar_ready !== 1'b0) begin n_fail++; $error("FAIL ar_ready_during_r: observed %0h", rsp.ar_ready); end
        tick();
        req.r_ready = 1'b0;
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        req       = '0;
        rd_lat    = 4'd0;
        rst_n     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        n_asserts++; if (rsp.ar_ready !== 1'b0) begin n_fail++; $error("FAIL rst_ar_ready: observed %0h", rsp.ar_ready); end
        n_asserts++; if (rsp.aw_ready !== 1'b0) begin n_fail++; $error("FAIL rst_aw_ready: observed %0h", rsp.aw_ready); end
        n_asserts++; if (rsp.w_ready !== 1'b0) begin n_fail++; $error("FAIL rst_w_ready: observed %0h", rsp.w_ready); end
        n_asserts++; if (rsp.r_valid !== 1'b0) begin n_fail++; $error("FAIL rst_r_valid: observed %0h", rsp.r_valid); end
        n_asserts++; if (rsp.b_valid !== 1'b0) begin n_fail++; $error("FAIL rst_b_valid: observed %0h", rsp.b_valid); end
        rst_n = 1'b1;
        tick();
        n_asserts++; if (rsp.ar_ready !== 1'b1) begin n_fail++; $error("FAIL post_rst_ar_ready: observed %0h", rsp.ar_ready); end
        n_asserts++; if (rsp.aw_ready !== 1'b1) begin n_fail++; $error("FAIL post_rst_aw_ready: observed %0h", rsp.aw_ready); end
        n_asserts++; if (rsp.w_ready !== 1'b0) begin n_fail++; $error("FAIL post_rst_w_ready: observed %0h", rsp.w_ready); end

        do_aw(4'd1, 64'h40);
        do_w(DAT_A, 8'hFF, 1'b0);
        do_w(DAT_B, 8'hFF, 1'b1);
        do_b(4'd1, RESP_OKAY);
        do_ar(4'd3, 64'h40, 8'd1);
        rd_beat(DAT_A, 4'd3, 1'b0, RESP_OKAY);
        rd_beat(DAT_B, 4'd3, 1'b1, RESP_OKAY);
        n_asserts++; if (rsp.ar_ready !== 1'b1) begin n_fail++; $error("FAIL ar_ready_after_last: observed %0h", rsp.ar_ready); end

        rd_lat = 4'd5;
        do_ar(4'd2, 64'h40, 8'd0);
        for (int i = 0; i < 5; i++) begin
            n_asserts++; if (rsp.r_valid !== 1'b0) begin n_fail++; $error("FAIL lat_r_valid_low: observed %0h", rsp.r_valid); end
            tick();
        end
        n_asserts++; if (rsp.r_valid !== 1'b1) begin n_fail++; $error("FAIL lat_r_valid_high: observed %0h", rsp.r_valid); end
        req.r_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_asserts++; if (rsp.r_valid !== 1'b1) begin n_fail++; $error("FAIL stall_r_valid: observed %0h", rsp.r_valid); end
            n_asserts++; if (rsp.r.data !== DAT_A) begin n_fail++; $error("FAIL stall_r_data: observed %0h", rsp.r.data); end
            n_asserts++; if (rsp.r.last !== 1'b1) begin n_fail++; $error("FAIL stall_r_last: observed %0h", rsp.r.last); end
            tick();
        end
        rd_beat(DAT_A, 4'd2, 1'b1, RESP_OKAY);
        rd_lat = 4'd0;

        do_aw(4'd5, 64'h100);
        do_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        do_b(4'd5, RESP_OKAY);
        do_aw(4'd6, 64'h100);
        do_w(64'h1111_1111_2222_2222, 8'h0F, 1'b1);
        do_b(4'd6, RESP_OKAY);
        do_ar(4'd7, 64'h100, 8'd0);
        rd_beat(64'hFFFF_FFFF_2222_2222, 4'd7, 1'b1, RESP_OKAY);

        do_aw(4'd4, BASE_HI);
        do_w(DAT_D0, 8'hFF, 1'b0);
        do_w(DAT_D1, 8'hFF, 1'b0);
        do_w(DAT_D2, 8'hFF, 1'b0);
        do_w(DAT_D3, 8'hFF, 1'b1);
`ifdef RV_IOMMU_DS_RSP_DECERR_EN
        do_b(4'd4, RESP_DECERR);
`else
        do_b(4'd4, RESP_OKAY);
`endif
        do_ar(4'd8, BASE_HI, 8'd3);
        rd_beat(DAT_D0, 4'd8, 1'b0, RESP_OKAY);
        rd_beat(DAT_D1, 4'd8, 1'b0, RESP_OKAY);
`ifdef RV_IOMMU_DS_RSP_DECERR_EN
        rd_beat(64'd0, 4'd8, 1'b0, RESP_DECERR);
        rd_beat(64'd0, 4'd8, 1'b1, RESP_DECERR);
`else
        rd_beat(DAT_D2, 4'd8, 1'b0, RESP_OKAY);
        rd_beat(DAT_D3, 4'd8, 1'b1, RESP_OKAY);
`endif

        req.w.data  = DAT_W0;
        req.w.strb  = 8'hFF;
        req.w.last  = 1'b0;
        req.w_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_asserts++; if (rsp.w_ready !== 1'b0) begin n_fail++; $error("FAIL early_w_ready_low: observed %0h", rsp.w_ready); end
            tick();
        end
        do_aw(4'd1, 64'h200);
        n_asserts++; if (rsp.w_ready !== 1'b1) begin n_fail++; $error("FAIL w_ready_after_aw: observed %0h", rsp.w_ready); end
        tick();
        req.w.data = DAT_W1;
        req.w.last = 1'b1;
        n_asserts++; if (rsp.w_ready !== 1'b1) begin n_fail++; $error("FAIL w_ready_beat2: observed %0h", rsp.w_ready); end
        tick();
        req.w_valid = 1'b0;
        do_b(4'd1, RESP_OKAY);
        do_ar(4'd9, 64'h200, 8'd1);
        rd_beat(DAT_W0, 4'd9, 1'b0, RESP_OKAY);
        rd_beat(DAT_W1, 4'd9, 1'b1, RESP_OKAY);

        do_ar(4'd10, BASE_HI, 8'd3);
        rd_beat(DAT_D0, 4'd10, 1'b0, RESP_OKAY);
        n_asserts++; if (rsp.r_valid !== 1'b1) begin n_fail++; $error("FAIL mid_r_valid_before_rst: observed %0h", rsp.r_valid); end
        rst_n = 1'b0;
        #1;
        n_asserts++; if (rsp.r_valid !== 1'b0) begin n_fail++; $error("FAIL rst_r_valid_drop: observed %0h", rsp.r_valid); end
        n_asserts++; if (rsp.ar_ready !== 1'b0) begin n_fail++; $error("FAIL rst_ar_ready_low: observed %0h", rsp.ar_ready); end
        req.r_ready = 1'b1;
        tick();
        n_asserts++; if (rsp.r_valid !== 1'b0) begin n_fail++; $error("FAIL rst_hold_r_valid: observed %0h", rsp.r_valid); end
        rst_n = 1'b1;
        req.r_ready = 1'b0;
        n_asserts++; if (rsp.ar_ready !== 1'b0) begin n_fail++; $error("FAIL rel_ar_ready_low: observed %0h", rsp.ar_ready); end
        tick();
        n_asserts++; if (rsp.ar_ready !== 1'b1) begin n_fail++; $error("FAIL rel_ar_ready_high: observed %0h", rsp.ar_ready); end
        n_asserts++; if (rsp.aw_ready !== 1'b1) begin n_fail++; $error("FAIL rel_aw_ready_high: observed %0h", rsp.aw_ready); end
        n_asserts++; if (rsp.r_valid !== 1'b0) begin n_fail++; $error("FAIL rel_r_valid_low: observed %0h", rsp.r_valid); end
        tick();
        n_asserts++; if (rsp.r_valid !== 1'b0) begin n_fail++; $error("FAIL rel_r_valid_stays_low: observed %0h", rsp.r_valid); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
